// File: rtl/cios_pkg.sv
// Types and helpers shared by the Montgomery datapath blocks (montcios, montredc).
// Latency: n/a. Backpressure: n/a.
package cios_pkg;

  localparam int unsigned LIMB_W = 32;

  typedef logic [LIMB_W-1:0] limb_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MCALC,
    ST_MAC,
    ST_CADD,
    ST_SUB,
    ST_FINAL
  } redc_state_e;

  // Accepted start edge to done cycle, in edges: S outer passes of (1 + S + 1), S subtract steps, one final.
  function automatic int unsigned redc_latency(input int unsigned s);
    return s * (s + 2) + s + 1;
  endfunction

endpackage

// File: rtl/mac_cell.sv
// Combinational multiply-accumulate {o_hi, o_lo} = i_a*i_b + i_c + i_d; cannot overflow 2*width bits.
// Latency: 0 cycles. Backpressure: none.
module mac_cell #(
  parameter int width = 32
) (
  input  logic [width-1:0] i_a,
  input  logic [width-1:0] i_b,
  input  logic [width-1:0] i_c,
  input  logic [width-1:0] i_d,
  output logic [width-1:0] o_hi,
  output logic [width-1:0] o_lo
);

  logic [2*width-1:0] w_prod;
  logic [2*width-1:0] w_sum;

  assign w_prod = {{width{1'b0}}, i_a} * {{width{1'b0}}, i_b};
  assign w_sum  = w_prod + {{width{1'b0}}, i_c} + {{width{1'b0}}, i_d};
  assign {o_hi, o_lo} = w_sum;

endmodule

// File: rtl/montredc.sv
// Word-serial Montgomery reduction r = t*R^-1 mod p with one shared MAC cell; latency S*(S+2)+S+1 edges.
// Backpressure: start is only sampled in IDLE with done low; busy covers the whole operation and the done cycle.
module montredc
  import cios_pkg::*;
#(
  parameter int width = 32,
  parameter int S     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [2*S-1:0][width-1:0]   t,
  input  logic [S-1:0][width-1:0]     p,
  input  logic [width-1:0]            p_inv,
  output logic [S-1:0][width-1:0]     r,
  output logic                        busy,
  output logic                        done
);

  localparam int CW = $clog2(S) + 1;
  localparam int JW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] LAST  = CW'(S - 1);
  localparam logic [CW-1:0] S_IDX = CW'(S);

  redc_state_e r_state;
  redc_state_e w_state_nxt;

  logic [2*S-1:0][width-1:0] r_tr;
  logic [S-1:0][width-1:0]   r_d;
  logic [S-1:0][width-1:0]   r_r;
  logic [width-1:0]          r_m;
  logic [width-1:0]          r_c;
  logic                      r_cb;
  logic                      r_bw;
  logic                      r_done;
  logic [CW-1:0]             r_i;
  logic [CW-1:0]             r_j;

  logic                      w_accept;
  logic [CW-1:0]             w_idx_mac;
  logic [CW-1:0]             w_idx_hi;
  logic [CW-1:0]             w_idx_sub;
  logic [JW-1:0]             w_jx;
  logic [width-1:0]          w_a;
  logic [width-1:0]          w_b;
  logic [width-1:0]          w_c;
  logic [width-1:0]          w_d;
  logic [width-1:0]          w_hi;
  logic [width-1:0]          w_lo;
  logic [width:0]            w_cadd;
  logic [width:0]            w_sub;

  assign w_accept  = (r_state == ST_IDLE) && start && !r_done;
  assign w_idx_mac = r_i + r_j;
  assign w_idx_hi  = r_i + S_IDX;
  assign w_idx_sub = S_IDX + r_j;
  assign w_jx      = r_j[JW-1:0];

  // MCALC borrows the cell for m = tr[i]*p_inv (low half only); MAC uses it as-is.
  always_comb begin
    w_a = r_m;
    w_b = p[w_jx];
    w_c = r_tr[w_idx_mac];
    w_d = r_c;
    if (r_state == ST_MCALC) begin
      w_a = r_tr[r_i];
      w_b = p_inv;
      w_c = '0;
      w_d = '0;
    end
  end

  mac_cell #(.width(width)) u_mac (
    .i_a (w_a),
    .i_b (w_b),
    .i_c (w_c),
    .i_d (w_d),
    .o_hi(w_hi),
    .o_lo(w_lo)
  );

  assign w_cadd = {1'b0, r_tr[w_idx_hi]} + {1'b0, r_c} + {{width{1'b0}}, r_cb};
  assign w_sub  = {1'b0, r_tr[w_idx_sub]} - {1'b0, p[w_jx]} - {{width{1'b0}}, r_bw};

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_MCALC;
      ST_MCALC: w_state_nxt = ST_MAC;
      ST_MAC:   if (r_j == LAST) w_state_nxt = ST_CADD;
      ST_CADD:  w_state_nxt = (r_i == LAST) ? ST_SUB : ST_MCALC;
      ST_SUB:   if (r_j == LAST) w_state_nxt = ST_FINAL;
      ST_FINAL: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tr   <= '0;
      r_d    <= '0;
      r_r    <= '0;
      r_m    <= '0;
      r_c    <= '0;
      r_cb   <= 1'b0;
      r_bw   <= 1'b0;
      r_done <= 1'b0;
      r_i    <= '0;
      r_j    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tr <= t;
            r_i  <= '0;
            r_cb <= 1'b0;
          end
        end
        ST_MCALC: begin
          r_m <= w_lo;
          r_c <= '0;
          r_j <= '0;
        end
        ST_MAC: begin
          r_tr[w_idx_mac] <= w_lo;
          r_c             <= w_hi;
          r_j             <= r_j + CW'(1);
        end
        ST_CADD: begin
          {r_cb, r_tr[w_idx_hi]} <= w_cadd;
          if (r_i == LAST) begin
            r_j  <= '0;
            r_bw <= 1'b0;
          end else begin
            r_i <= r_i + CW'(1);
          end
        end
        ST_SUB: begin
          {r_bw, r_d[w_jx]} <= w_sub;
          r_j               <= r_j + CW'(1);
        end
        ST_FINAL: begin
          // Carry out of the top limb means the value is >= R > p, so the difference is the answer.
          r_r    <= (r_cb || !r_bw) ? r_d : r_tr[2*S-1:S];
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign r    = r_r;
  assign done = r_done;
  assign busy = (r_state != ST_IDLE) || r_done;

endmodule

// File: tb/tb_montredc.sv
// Randomised and directed bench for montredc: scoreboard queues checked by a negedge monitor
// against a reference of t*R^-1 mod p computed by repeated modular halving.
module tb_montredc;

  localparam int L_S = 11;
  localparam int L_L = 89;

  typedef struct {
    logic [255:0] exp;
    int           acc;
    bit           modp;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_s, start_l;
  logic [31:0]  t_s;
  logic [15:0]  p_s;
  logic [7:0]   pi_s;
  logic [15:0]  r_s;
  logic         busy_s, done_s;
  logic [511:0] t_l;
  logic [255:0] p_l;
  logic [31:0]  pi_l;
  logic [255:0] r_l;
  logic         busy_l, done_l;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_s[$];
  exp_t q_l[$];
  exp_t e_s, e_l;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  montredc #(.width(8), .S(2)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .t(t_s), .p(p_s), .p_inv(pi_s),
    .r(r_s), .busy(busy_s), .done(done_s)
  );

  montredc #(.width(32), .S(8)) dut_l (
    .clk(clk), .rst(rst), .start(start_l), .t(t_l), .p(p_l), .p_inv(pi_l),
    .r(r_l), .busy(busy_l), .done(done_l)
  );

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // t*2^-nbits mod p: reduce, then halve modulo p nbits times.
  function automatic logic [255:0] ref_redc(input logic [511:0] t, input logic [255:0] p, input int nbits);
    logic [511:0] x;
    logic [511:0] pp;
    pp = {256'b0, p};
    x  = t % pp;
    for (int k = 0; k < nbits; k++) x = x[0] ? ((x + pp) >> 1) : (x >> 1);
    return x[255:0];
  endfunction

  function automatic logic [31:0] neg_inv32(input logic [31:0] p0);
    logic [31:0] v;
    v = p0;
    for (int k = 0; k < 5; k++) v = v * (32'd2 - p0 * v);
    return -v;
  endfunction

  always @(negedge clk) begin
    chk("busy_s", {255'b0, busy_s}, {255'b0, q_s.size() != 0});
    chk("busy_l", {255'b0, busy_l}, {255'b0, q_l.size() != 0});
    if (done_s) begin
      if (q_s.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done_s done=1 required=0 r=%h", r_s);
      end else begin
        e_s = q_s.pop_front();
        chk("result_s", e_s.modp ? {240'b0, r_s % p_s} : {240'b0, r_s}, e_s.exp);
        chk("latency_s", 256'(cyc - e_s.acc), 256'(L_S));
      end
    end
    if (done_l) begin
      if (q_l.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done_l done=1 required=0");
      end else begin
        e_l = q_l.pop_front();
        chk("result_l", r_l, e_l.exp);
        chk("latency_l", 256'(cyc - e_l.acc), 256'(L_L));
      end
    end
  end

  task automatic drain_s();
    int k;
    k = 0;
    while (q_s.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (q_s.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_s pending=%0d required=0", q_s.size());
      q_s.delete();
    end
    #1;
  endtask

  task automatic drain_l();
    int k;
    k = 0;
    while (q_l.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (q_l.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_l pending=%0d required=0", q_l.size());
      q_l.delete();
    end
    #1;
  endtask

  // Called #1 after a posedge with the DUT idle; start is accepted on the next edge.
  task automatic issue_s(input logic [31:0] t, input logic [15:0] p, input logic [7:0] pinv, input bit modp);
    exp_t e;
    t_s = t; p_s = p; pi_s = pinv; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    e.exp = ref_redc({480'b0, t}, {240'b0, p}, 16);
    e.acc = cyc;
    e.modp = modp;
    q_s.push_back(e);
    drain_s();
  endtask

  task automatic issue_l(input logic [511:0] t, input logic [255:0] p, input logic [31:0] pinv);
    exp_t e;
    t_l = t; p_l = p; pi_l = pinv; start_l = 1'b1;
    @(posedge clk); #1;
    start_l = 1'b0;
    e.exp = ref_redc(t, p, 256);
    e.acc = cyc;
    e.modp = 1'b0;
    q_l.push_back(e);
    drain_l();
  endtask

  initial begin
    logic [255:0] rp;
    logic [511:0] rt;
    logic [31:0]  ninv;
    logic [15:0]  sp;
    logic [63:0]  st;
    exp_t         ab;

    rst = 1'b1;
    start_s = 1'b0; start_l = 1'b0;
    t_s = '0; p_s = 16'h0001; pi_s = '0;
    t_l = '0; p_l = 256'h1; pi_l = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_r_s", {240'b0, r_s}, 256'h0);
    chk("reset_busy_s", {255'b0, busy_s}, 256'h0);
    chk("reset_done_s", {255'b0, done_s}, 256'h0);
    chk("reset_r_l", r_l, 256'h0);
    chk("reset_busy_l", {255'b0, busy_l}, 256'h0);
    chk("reset_done_l", {255'b0, done_l}, 256'h0);
    rst = 1'b0;

    // R*R^-1 = 1; all-ones t lands above p*R so only the residue class is defined.
    issue_s(32'h0001_0000, 16'hFFFF, 8'h01, 1'b0);
    issue_s(32'hFFFF_FFFF, 16'hFFFF, 8'h01, 1'b1);
    issue_s(32'h0000_FFF1, 16'hFFF1, 8'hEF, 1'b0);
    issue_s(32'hFFF0_0000, 16'hFFF1, 8'hEF, 1'b0);

    // Abort mid-operation: a start during busy is ignored, reset drops the request.
    t_s = 32'h0001_0000; p_s = 16'hFFFF; pi_s = 8'h01; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    ab.exp = 256'h1; ab.acc = cyc; ab.modp = 1'b0;
    q_s.push_back(ab);
    repeat (2) @(posedge clk);
    #1 start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    q_s.delete();
    chk("abort_r_s", {240'b0, r_s}, 256'h0);
    chk("abort_busy_s", {255'b0, busy_s}, 256'h0);
    chk("abort_done_s", {255'b0, done_s}, 256'h0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    issue_s(32'h1234_5678, 16'hFFF1, 8'hEF, 1'b0);

    for (int n = 0; n < 20; n++) begin
      sp = 16'($urandom) | 16'h0001;
      ninv = neg_inv32({16'b0, sp});
      st = {32'b0, 32'($urandom)} % ({48'b0, sp} << 16);
      issue_s(st[31:0], sp, ninv[7:0], 1'b0);
    end

    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 8; k++) rp[32*k +: 32] = $urandom;
      rp[0] = 1'b1;
      for (int k = 0; k < 16; k++) rt[32*k +: 32] = $urandom;
      rt = rt % ({256'b0, rp} << 256);
      issue_l(rt, rp, neg_inv32(rp[31:0]));
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
